// File: rtl/lcd_rx_monitor.sv
// LCD RGB receive monitor: sync lock tracking, pixel position decode,
// single-pixel probe and per-frame checksum.
module lcd_rx_monitor #(
  parameter int H_TOTAL  = 526,
  parameter int V_TOTAL  = 286,
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int H_OFFSET = 43,
  parameter int V_OFFSET = 12
) (
  input  logic        clk12,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        disp,
  input  logic [23:0] bgr,
  input  logic [8:0]  probe_x,
  input  logic [8:0]  probe_y,
  output logic [8:0]  x,
  output logic [8:0]  y,
  output logic        pix_valid,
  output logic [23:0] probe_bgr,
  output logic        probe_valid,
  output logic [23:0] frame_sum,
  output logic        frame_done,
  output logic        locked,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    HUNT,
    ALIGN,
    LOCKED
  } state_t;

  localparam logic [9:0] H_LO = 10'(H_OFFSET);
  localparam logic [9:0] H_HI = 10'(H_OFFSET + H_ACTIVE - 1);
  localparam logic [8:0] V_LO = 9'(V_OFFSET);
  localparam logic [8:0] V_HI = 9'(V_OFFSET + V_ACTIVE - 1);
  localparam logic [8:0] X_LAST = 9'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

  state_t      state;
  state_t      state_n;
  logic        hs_q;
  logic        vs_q;
  logic        hrise;
  logic        vrise;
  logic [9:0]  hcnt;
  logic [8:0]  lcnt;
  logic        first_h;
  logic        bad;
  logic [23:0] acc;
  logic        err_inc;
  logic        len_bad;
  logic        in_h;
  logic        in_v;
  logic        last_pix;
  logic        probe_hit;

  assign hrise   = hsync & ~hs_q;
  assign vrise   = vsync & ~vs_q;
  assign len_bad = ({1'b0, hcnt} + 11'd1) != 11'(H_TOTAL);

  assign in_h = (hcnt >= H_LO) && (hcnt <= H_HI);
  assign in_v = (lcnt >= V_LO) && (lcnt <= V_HI);

  assign locked    = (state == LOCKED);
  assign pix_valid = locked && in_h && in_v;
  assign x = pix_valid ? (hcnt[8:0] - H_LO[8:0]) : 9'd0;
  assign y = pix_valid ? (lcnt - V_LO) : 9'd0;

  // a pixel that coincides with losing lock does not close the frame
  assign last_pix  = pix_valid && (x == X_LAST) &&
                     (y == Y_LAST) && (state_n == LOCKED);
  assign probe_hit = pix_valid && (x == probe_x) &&
                     (y == probe_y);

  always_comb begin
    state_n = state;
    err_inc = 1'b0;
    if (!disp) begin
      state_n = HUNT;
    end else begin
      unique case (state)
        HUNT: begin
          if (vrise) state_n = ALIGN;
        end
        ALIGN: begin
          if (vrise) begin
            if (!bad && lcnt == 9'(V_TOTAL))
              state_n = LOCKED;
            else
              state_n = HUNT;
          end
        end
        LOCKED: begin
          if (vrise) begin
            if (lcnt != 9'(V_TOTAL)) begin
              state_n = HUNT;
              err_inc = 1'b1;
            end
          end else if (hrise && !first_h && len_bad) begin
            state_n = HUNT;
            err_inc = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk12) begin
    if (reset) begin
      state       <= HUNT;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hcnt        <= 10'd0;
      lcnt        <= 9'd0;
      first_h     <= 1'b1;
      bad         <= 1'b0;
      acc         <= 24'd0;
      frame_sum   <= 24'd0;
      frame_done  <= 1'b0;
      probe_bgr   <= 24'd0;
      probe_valid <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state <= state_n;
      hs_q  <= hsync;
      vs_q  <= vsync;

      if (hrise)
        hcnt <= 10'd0;
      else if (hcnt != 10'h3FF)
        hcnt <= hcnt + 10'd1;

      if (vrise)
        lcnt <= 9'd0;
      else if (hrise && lcnt != 9'h1FF)
        lcnt <= lcnt + 9'd1;

      // first line after vsync is only counted, never length-checked
      if (vrise)
        first_h <= 1'b1;
      else if (hrise)
        first_h <= 1'b0;

      if (vrise)
        bad <= 1'b0;
      else if (hrise && !first_h && len_bad)
        bad <= 1'b1;

      if (vrise || !locked)
        acc <= 24'd0;
      else if (pix_valid)
        acc <= acc + bgr;

      frame_done <= last_pix;
      if (last_pix)
        frame_sum <= acc + bgr;

      probe_valid <= probe_hit;
      if (probe_hit)
        probe_bgr <= bgr;

      if (err_inc && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule
